spi_daisy_slave: RTL and testbench
==================================

Name: spi_daisy_slave

Overview:
Parametrised successor to the dual-SPI daisy test block. Provides a broadcast (global) SPI receive channel and a daisy-chain SPI channel: full-duplex, pass-through, with a local transmit word. Both channels are oversampled on the system clock. Frames are checked on CS deassertion. An open-drain READY line is driven from a core done flag. The block sits between the external SPI pins and the core logic.

Parameters:
WIDTH, 32, bits per frame word for both channels (2..256)
SYNC_STAGES, 2, synchroniser flops on every SCK/SDI/CS input (>=2)

Ports:
clk_in  in  1  system clock; all logic is on its rising edge
reset_n_in  in  1  asynchronous, active-low reset
sck0_in  in  1  global SPI clock (mode 0)
sdi0_in  in  1  global SPI data in
cs0_n_in  in  1  global chip select, active low
sck1_in  in  1  daisy SPI clock (mode 0)
sdi1_in  in  1  daisy data in, from upstream device
sdo1_out  out  1  daisy data out, to downstream device
cs1_n_in  in  1  daisy chip select, active low
tx1_data_in  in  WIDTH  local word loaded into the daisy shifter at frame start
rx0_data_out  out  WIDTH  last valid global frame
rx0_valid_out  out  1  one-cycle pulse: rx0_data_out updated
rx0_err_out  out  1  one-cycle pulse: global frame length error
rx1_data_out  out  WIDTH  last WIDTH bits held in the daisy shifter at valid frame end
rx1_valid_out  out  1  one-cycle pulse: rx1_data_out updated
rx1_err_out  out  1  one-cycle pulse: daisy frame length error
done_in  in  1  core done flag
ready_n_ts_out  out  1  0 when done_in=1, else high-Z (open drain)

Behaviour:
- Sync: each of sck/sdi/cs per channel passes through a SYNC_STAGES-deep flop chain, then one delay flop for edge detect. Every action is registered at the edge that sees the detect.
- Latency: pin change sampled at clk edge k -> action visible after edge k+SYNC_STAGES.
- Reset values: all shifters, counters, rx*_data_out = 0. Pulses = 0. sdo1_out = 0. Sync chains reset to idle: cs=1, sck=0. armed flags = 0.
- armed flag per channel: set when synchronised CS is seen high. A frame is processed only if armed. This discards a frame already in progress at reset release.
- Global channel:
  - On sync CS fall: bit counter cleared.
  - While sync CS low: each sync SCK rise shifts sdi into the LSB, MSB-first.
  - Counter saturates at WIDTH+1.
  - On sync CS rise: counter==WIDTH -> rx0_data_out <= shifter and rx0_valid_out pulses. Otherwise rx0_err_out pulses and data is unchanged.
- Daisy channel:
  - On sync CS fall: shifter <= tx1_data_in, sdo1_out <= tx1_data_in[WIDTH-1], mod-WIDTH counter cleared, word_seen cleared.
  - On SCK rise: shift sdi into the LSB. The counter increments and wraps at WIDTH; word_seen is set on the wrap.
  - On SCK fall: sdo1_out <= shifter[WIDTH-1].
  - On CS rise: word_seen=1 and counter=0 -> rx1_data_out <= shifter and rx1_valid_out pulses. Otherwise rx1_err_out pulses.
  - Valid daisy frame lengths are N*WIDTH bits, N>=1. Data from an N-device chain passes through with WIDTH bits delay per device.
- SCK edges are ignored while sync CS is high.
- CS edge and SCK edge detected in the same cycle: the CS action wins and the SCK edge is dropped.
- sdo1_out holds its value while CS is high. It is never tri-stated.
- The two channels are fully independent. Simultaneous activity on both is legal.
- ready_n_ts_out is purely combinational from done_in.
- Reset assertion mid-frame clears everything immediately. No pulse is emitted for the aborted frame.

Test Plan:
1. Global frame: clock 0xDEADBEEF MSB-first, WIDTH=32, SCK at clk/8 -> rx0_data_out=0xDEADBEEF. rx0_valid_out is high exactly 1 cycle, 2 clk after CS high is sampled. rx0_err_out=0.
2. Global short frame: 31 bits, then 33 bits -> rx0_err_out pulses each time. rx0_data_out keeps 0xDEADBEEF.
3. Daisy single: tx1_data_in=0x12345678, shift in 0xCAFEF00D over 32 clocks -> sdo1_out emits 0x12345678 MSB-first (each bit stable across the SCK rise). rx1_data_out=0xCAFEF00D, valid pulse.
4. Daisy pass-through: 64-bit frame 0xAAAA5555_0F0F0F0F -> sdo1_out emits tx word, then 0xAAAA5555. rx1_data_out=0x0F0F0F0F. 40-bit frame -> rx1_err_out pulse.
5. Reset mid-frame: assert reset_n_in after 10 global bits, release with CS still low, finish frame -> no valid/err pulse. Next full frame is received correctly.
6. done_in 0->1->0 -> ready_n_ts_out goes Z -> 0 -> Z. CS rise coincident with an SCK rise -> bit dropped, counter unchanged.

Source files
------------

// File: rtl/spi_daisy_slave.sv
// spi_daisy_slave: oversampled SPI slave with a broadcast receive channel
// (channel 0) and a full-duplex daisy-chain channel (channel 1). Every pin
// is synchronised to clk_in and its edges are detected from the synchronised
// value. Frames are checked when chip select returns high.
module spi_daisy_slave #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_in,
  input  logic             reset_n_in,
  input  logic             sck0_in,
  input  logic             sdi0_in,
  input  logic             cs0_n_in,
  input  logic             sck1_in,
  input  logic             sdi1_in,
  output logic             sdo1_out,
  input  logic             cs1_n_in,
  input  logic [WIDTH-1:0] tx1_data_in,
  output logic [WIDTH-1:0] rx0_data_out,
  output logic             rx0_valid_out,
  output logic             rx0_err_out,
  output logic [WIDTH-1:0] rx1_data_out,
  output logic             rx1_valid_out,
  output logic             rx1_err_out,
  input  logic             done_in,
  output tri               ready_n_ts_out
);

  // Channel 0 counter must hold WIDTH+1 so that over-long frames saturate.
  localparam int CW0 = $clog2(WIDTH + 2);
  localparam int CW1 = $clog2(WIDTH);
  localparam logic [CW0-1:0] L_CNT0_FULL = CW0'(WIDTH);
  localparam logic [CW0-1:0] L_CNT0_SAT  = CW0'(WIDTH + 1);
  localparam logic [CW0-1:0] L_CNT0_ONE  = CW0'(1);
  localparam logic [CW1-1:0] L_CNT1_LAST = CW1'(WIDTH - 1);
  localparam logic [CW1-1:0] L_CNT1_ONE  = CW1'(1);
  // Bit order of the sync vector: {cs1, sdi1, sck1, cs0, sdi0, sck0}.
  localparam logic [5:0]     L_SYNC_IDLE = 6'b100100;

  logic [5:0]             r_sync [SYNC_STAGES];
  logic [3:0]             r_dly;     // {cs1, sck1, cs0, sck0} one cycle late
  logic [SYNC_STAGES-1:0] r_fill;    // marks sync outputs as real pin samples

  logic [5:0] w_s;
  logic       w_sck0, w_sdi0, w_cs0, w_sck1, w_sdi1, w_cs1;
  logic       w_live;
  logic       w_cs0_fall, w_cs0_rise, w_sck0_rise;
  logic       w_cs1_fall, w_cs1_rise, w_sck1_rise, w_sck1_fall;

  logic             r_armed0;
  logic [WIDTH-1:0] r_sh0;
  logic [CW0-1:0]   r_cnt0;
  logic [WIDTH-1:0] r_rx0;
  logic             r_v0;
  logic             r_e0;

  logic             r_armed1;
  logic [WIDTH-1:0] r_sh1;
  logic [CW1-1:0]   r_cnt1;
  logic             r_seen1;
  logic             r_sdo1;
  logic [WIDTH-1:0] r_rx1;
  logic             r_v1;
  logic             r_e1;

  assign w_s    = r_sync[SYNC_STAGES-1];
  assign w_sck0 = w_s[0];
  assign w_sdi0 = w_s[1];
  assign w_cs0  = w_s[2];
  assign w_sck1 = w_s[3];
  assign w_sdi1 = w_s[4];
  assign w_cs1  = w_s[5];
  // The chains reset to idle, so only arm once they carry genuine samples;
  // otherwise a frame in progress at reset release would be half-received.
  assign w_live = r_fill[SYNC_STAGES-1];

  assign w_cs0_fall  =  r_dly[1] & ~w_cs0;
  assign w_cs0_rise  = ~r_dly[1] &  w_cs0;
  assign w_sck0_rise = ~r_dly[0] &  w_sck0 & ~w_cs0;
  assign w_cs1_fall  =  r_dly[3] & ~w_cs1;
  assign w_cs1_rise  = ~r_dly[3] &  w_cs1;
  assign w_sck1_rise = ~r_dly[2] &  w_sck1 & ~w_cs1;
  assign w_sck1_fall =  r_dly[2] & ~w_sck1 & ~w_cs1;

  // Synchronise all pins, keep one delayed copy of SCK/CS for edge detect.
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= L_SYNC_IDLE;
      r_dly  <= 4'b1010;
      r_fill <= {SYNC_STAGES{1'b0}};
    end else begin
      r_sync[0] <= {cs1_n_in, sdi1_in, sck1_in, cs0_n_in, sdi0_in, sck0_in};
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_dly  <= {w_cs1, w_sck1, w_cs0, w_sck0};
      r_fill <= {r_fill[SYNC_STAGES-2:0], 1'b1};
    end
  end

  // Global channel: shift on SCK rise, validate the bit count on CS rise.
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      r_armed0 <= 1'b0;
      r_sh0    <= {WIDTH{1'b0}};
      r_cnt0   <= {CW0{1'b0}};
      r_rx0    <= {WIDTH{1'b0}};
      r_v0     <= 1'b0;
      r_e0     <= 1'b0;
    end else begin
      r_v0 <= 1'b0;
      r_e0 <= 1'b0;
      if (w_live && w_cs0) r_armed0 <= 1'b1;
      if (r_armed0) begin
        if (w_cs0_fall) begin
          r_cnt0 <= {CW0{1'b0}};
        end else if (w_cs0_rise) begin
          if (r_cnt0 == L_CNT0_FULL) begin
            r_rx0 <= r_sh0;
            r_v0  <= 1'b1;
          end else begin
            r_e0  <= 1'b1;
          end
        end else if (w_sck0_rise) begin
          r_sh0 <= {r_sh0[WIDTH-2:0], w_sdi0};
          if (r_cnt0 != L_CNT0_SAT) r_cnt0 <= r_cnt0 + L_CNT0_ONE;
        end
      end
    end
  end

  // Daisy channel: load local word on CS fall, shift in on SCK rise, drive
  // the MSB out on SCK fall, accept only whole multiples of WIDTH on CS rise.
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      r_armed1 <= 1'b0;
      r_sh1    <= {WIDTH{1'b0}};
      r_cnt1   <= {CW1{1'b0}};
      r_seen1  <= 1'b0;
      r_sdo1   <= 1'b0;
      r_rx1    <= {WIDTH{1'b0}};
      r_v1     <= 1'b0;
      r_e1     <= 1'b0;
    end else begin
      r_v1 <= 1'b0;
      r_e1 <= 1'b0;
      if (w_live && w_cs1) r_armed1 <= 1'b1;
      if (r_armed1) begin
        if (w_cs1_fall) begin
          r_sh1   <= tx1_data_in;
          r_sdo1  <= tx1_data_in[WIDTH-1];
          r_cnt1  <= {CW1{1'b0}};
          r_seen1 <= 1'b0;
        end else if (w_cs1_rise) begin
          if (r_seen1 && (r_cnt1 == {CW1{1'b0}})) begin
            r_rx1 <= r_sh1;
            r_v1  <= 1'b1;
          end else begin
            r_e1  <= 1'b1;
          end
        end else if (w_sck1_rise) begin
          r_sh1 <= {r_sh1[WIDTH-2:0], w_sdi1};
          if (r_cnt1 == L_CNT1_LAST) begin
            r_cnt1  <= {CW1{1'b0}};
            r_seen1 <= 1'b1;
          end else begin
            r_cnt1  <= r_cnt1 + L_CNT1_ONE;
          end
        end else if (w_sck1_fall) begin
          r_sdo1 <= r_sh1[WIDTH-1];
        end
      end
    end
  end

  assign rx0_data_out  = r_rx0;
  assign rx0_valid_out = r_v0;
  assign rx0_err_out   = r_e0;
  assign rx1_data_out  = r_rx1;
  assign rx1_valid_out = r_v1;
  assign rx1_err_out   = r_e1;
  assign sdo1_out      = r_sdo1;

  // Open-drain READY: pull low while the core reports done, else release.
  assign ready_n_ts_out = done_in ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_spi_daisy_slave.sv
// Directed testbench for spi_daisy_slave (WIDTH=32, SYNC_STAGES=2).
module tb_spi_daisy_slave;

  logic        clk_in = 1'b0;
  logic        reset_n_in;
  logic        sck0_in, sdi0_in, cs0_n_in;
  logic        sck1_in, sdi1_in, cs1_n_in;
  logic        sdo1_out;
  logic [31:0] tx1_data_in;
  logic [31:0] rx0_data_out, rx1_data_out;
  logic        rx0_valid_out, rx0_err_out, rx1_valid_out, rx1_err_out;
  logic        done_in;
  wire         ready_w;

  int n_tests = 0;
  int n_fail  = 0;
  int n_v0 = 0, n_e0 = 0, n_v1 = 0, n_e1 = 0;
  int snap_v, snap_e;
  logic [63:0] sdo_a, sdo_b;

  pullup (ready_w);

  always #5 clk_in = ~clk_in;

  spi_daisy_slave #(.WIDTH(32), .SYNC_STAGES(2)) dut (
    .clk_in        (clk_in),
    .reset_n_in    (reset_n_in),
    .sck0_in       (sck0_in),
    .sdi0_in       (sdi0_in),
    .cs0_n_in      (cs0_n_in),
    .sck1_in       (sck1_in),
    .sdi1_in       (sdi1_in),
    .sdo1_out      (sdo1_out),
    .cs1_n_in      (cs1_n_in),
    .tx1_data_in   (tx1_data_in),
    .rx0_data_out  (rx0_data_out),
    .rx0_valid_out (rx0_valid_out),
    .rx0_err_out   (rx0_err_out),
    .rx1_data_out  (rx1_data_out),
    .rx1_valid_out (rx1_valid_out),
    .rx1_err_out   (rx1_err_out),
    .done_in       (done_in),
    .ready_n_ts_out(ready_w)
  );

  // Count every pulse on the four strobe outputs.
  always @(negedge clk_in) begin
    if (rx0_valid_out === 1'b1) n_v0 <= n_v0 + 1;
    if (rx0_err_out   === 1'b1) n_e0 <= n_e0 + 1;
    if (rx1_valid_out === 1'b1) n_v1 <= n_v1 + 1;
    if (rx1_err_out   === 1'b1) n_e1 <= n_e1 + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Global bits MSB-first, SCK = clk/8.
  task automatic g_bits(input logic [63:0] d, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      sdi0_in = d[i];
      tick(4);
      sck0_in = 1'b1;
      tick(4);
      sck0_in = 1'b0;
    end
  endtask

  task automatic g_frame(input logic [63:0] d, input int n);
    cs0_n_in = 1'b0;
    tick(4);
    g_bits(d, n);
    tick(4);
    cs0_n_in = 1'b1;
    tick(8);
  endtask

  // Daisy frame; sdo sampled just before each SCK rise (a) and before fall (b).
  task automatic d_frame(input logic [63:0] d, input int n,
                         output logic [63:0] a, output logic [63:0] b);
    a = 64'h0;
    b = 64'h0;
    cs1_n_in = 1'b0;
    tick(4);
    for (int i = n - 1; i >= 0; i--) begin
      sdi1_in = d[i];
      tick(4);
      a = {a[62:0], sdo1_out};
      sck1_in = 1'b1;
      tick(4);
      b = {b[62:0], sdo1_out};
      sck1_in = 1'b0;
    end
    tick(4);
    cs1_n_in = 1'b1;
    tick(8);
  endtask

  initial begin
    reset_n_in = 1'b0;
    sck0_in = 1'b0; sdi0_in = 1'b0; cs0_n_in = 1'b1;
    sck1_in = 1'b0; sdi1_in = 1'b0; cs1_n_in = 1'b1;
    tx1_data_in = 32'h0;
    done_in = 1'b0;
    tick(3);

    // Reset state
    chk("rst_rx0", {32'h0, rx0_data_out}, 64'h0);
    chk("rst_rx1", {32'h0, rx1_data_out}, 64'h0);
    chk("rst_sdo1", {63'h0, sdo1_out}, 64'h0);
    chk("rst_pulses", {60'h0, rx0_valid_out, rx0_err_out, rx1_valid_out, rx1_err_out}, 64'h0);
    reset_n_in = 1'b1;
    tick(8);

    // 1: global 0xDEADBEEF with exact pulse timing
    cs0_n_in = 1'b0;
    tick(4);
    g_bits(64'hDEADBEEF, 32);
    tick(4);
    cs0_n_in = 1'b1;
    tick(2);
    chk("g1_valid_early", {63'h0, rx0_valid_out}, 64'h0);
    tick(1);
    chk("g1_valid_pulse", {63'h0, rx0_valid_out}, 64'h1);
    chk("g1_data", {32'h0, rx0_data_out}, 64'hDEADBEEF);
    tick(1);
    chk("g1_valid_after", {63'h0, rx0_valid_out}, 64'h0);
    tick(6);
    chk("g1_err_cnt", 64'(n_e0), 64'd0);
    chk("g1_valid_cnt", 64'(n_v0), 64'd1);

    // 2: short and long global frames
    g_frame(64'h12345678, 31);
    chk("g2_err31", 64'(n_e0), 64'd1);
    g_frame(64'h1_2345_6789, 33);
    chk("g2_err33", 64'(n_e0), 64'd2);
    chk("g2_data_kept", {32'h0, rx0_data_out}, 64'hDEADBEEF);
    chk("g2_no_valid", 64'(n_v0), 64'd1);

    // 3: daisy single word
    tx1_data_in = 32'h12345678;
    d_frame(64'hCAFEF00D, 32, sdo_a, sdo_b);
    chk("d3_sdo_pre_rise", sdo_a, 64'h12345678);
    chk("d3_sdo_post_rise", sdo_b, 64'h12345678);
    chk("d3_rx1", {32'h0, rx1_data_out}, 64'hCAFEF00D);
    chk("d3_valid_cnt", 64'(n_v1), 64'd1);
    chk("d3_err_cnt", 64'(n_e1), 64'd0);

    // 4: daisy pass-through, then a 40-bit error frame
    d_frame(64'hAAAA5555_0F0F0F0F, 64, sdo_a, sdo_b);
    chk("d4_sdo_pass", sdo_a, 64'h12345678_AAAA5555);
    chk("d4_sdo_stable", sdo_b, 64'h12345678_AAAA5555);
    chk("d4_rx1", {32'h0, rx1_data_out}, 64'h0F0F0F0F);
    chk("d4_valid_cnt", 64'(n_v1), 64'd2);
    d_frame(64'h00_1122334455, 40, sdo_a, sdo_b);
    chk("d4_err40", 64'(n_e1), 64'd1);
    chk("d4_rx1_kept", {32'h0, rx1_data_out}, 64'h0F0F0F0F);

    // 5: reset mid-frame, frame completes with no pulse
    snap_v = n_v0;
    snap_e = n_e0;
    cs0_n_in = 1'b0;
    tick(4);
    g_bits(64'h3FF, 10);
    reset_n_in = 1'b0;
    tick(2);
    chk("r5_rx0_cleared", {32'h0, rx0_data_out}, 64'h0);
    reset_n_in = 1'b1;
    g_bits(64'h3FFFFF, 22);
    tick(4);
    cs0_n_in = 1'b1;
    tick(8);
    chk("r5_no_valid", 64'(n_v0), 64'(snap_v));
    chk("r5_no_err", 64'(n_e0), 64'(snap_e));
    g_frame(64'h13579BDF, 32);
    chk("r5_next_data", {32'h0, rx0_data_out}, 64'h13579BDF);
    chk("r5_next_valid", 64'(n_v0), 64'(snap_v + 1));

    // 6: open-drain READY
    chk("ready_idle", {63'h0, ready_w}, 64'h1);
    done_in = 1'b1;
    tick(1);
    chk("ready_done", {63'h0, ready_w}, 64'h0);
    done_in = 1'b0;
    tick(1);
    chk("ready_release", {63'h0, ready_w}, 64'h1);

    // 6: CS rise coincident with SCK rise drops the 32nd bit
    snap_v = n_v0;
    snap_e = n_e0;
    cs0_n_in = 1'b0;
    tick(4);
    g_bits(64'h2468ACE0, 31);
    sdi0_in = 1'b1;
    tick(4);
    sck0_in = 1'b1;
    cs0_n_in = 1'b1;
    tick(4);
    sck0_in = 1'b0;
    tick(8);
    chk("c6_err", 64'(n_e0), 64'(snap_e + 1));
    chk("c6_no_valid", 64'(n_v0), 64'(snap_v));
    chk("c6_data_kept", {32'h0, rx0_data_out}, 64'h13579BDF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
